// File: rtl/imem_dmem_arbiter.sv
// Shares one single-port synchronous SRAM between instruction fetch and data access.
// Data accesses have priority; a burst counter forces an IF grant after MAX_D_BURST data grants.
module imem_dmem_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MAX_D_BURST = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_req,
  input  logic [ADDR_W-1:0]     if_addr,
  output logic                  if_wait,
  output logic                  if_rvalid,
  output logic [DATA_W-1:0]     if_rdata,
  input  logic                  d_req,
  input  logic [DATA_W/8-1:0]   d_web,
  input  logic [ADDR_W-1:0]     d_addr,
  input  logic [DATA_W-1:0]     d_wdata,
  output logic                  d_wait,
  output logic                  d_rvalid,
  output logic [DATA_W-1:0]     d_rdata,
  output logic                  mem_cs,
  output logic                  mem_oe,
  output logic [DATA_W/8-1:0]   mem_web,
  output logic [ADDR_W-3:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_di,
  input  logic [DATA_W-1:0]     mem_do
);

  localparam int BE_W = DATA_W / 8;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_DRD  = 2'd2,
    OWN_DWR  = 2'd3
  } owner_t;

  owner_t      r_owner;
  owner_t      w_owner_next;
  logic [3:0]  r_burst_cnt;
  logic [3:0]  w_burst_next;
  logic        w_burst_full;
  logic        w_gnt_d;
  logic        w_gnt_if;
  logic        w_d_write;
  logic [ADDR_W-1:0] w_addr_sel;
  logic        w_unused_addr_bits;

  // Word addressing drops the byte offset of both requesters.
  assign w_unused_addr_bits = ^{if_addr[1:0], d_addr[1:0]};

  assign w_burst_full = (r_burst_cnt == 4'(MAX_D_BURST));
  assign w_gnt_d      = d_req & ~(if_req & w_burst_full);
  assign w_gnt_if     = if_req & ~w_gnt_d;
  assign w_d_write    = |d_web;

  assign if_wait = if_req & ~w_gnt_if;
  assign d_wait  = d_req & ~w_gnt_d;

  assign w_addr_sel = w_gnt_d ? d_addr : if_addr;
  assign mem_cs     = w_gnt_d | w_gnt_if;
  assign mem_oe     = mem_cs & ~(w_gnt_d & w_d_write);
  assign mem_web    = w_gnt_d ? d_web : {BE_W{1'b0}};
  assign mem_addr   = mem_cs ? w_addr_sel[ADDR_W-1:2] : '0;
  assign mem_di     = w_gnt_d ? d_wdata : '0;

  always_comb begin
    w_owner_next = OWN_NONE;
    w_burst_next = r_burst_cnt;
    if (w_gnt_d) begin
      w_owner_next = w_d_write ? OWN_DWR : OWN_DRD;
    end else if (w_gnt_if) begin
      w_owner_next = OWN_IF;
    end
    // The counter only measures how long a pending fetch has been passed over.
    if (!if_req || w_gnt_if) begin
      w_burst_next = 4'd0;
    end else if (w_gnt_d && !w_burst_full) begin
      w_burst_next = r_burst_cnt + 4'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_owner     <= OWN_NONE;
      r_burst_cnt <= 4'd0;
    end else begin
      r_owner     <= w_owner_next;
      r_burst_cnt <= w_burst_next;
    end
  end

  always_comb begin
    if_rvalid = 1'b0;
    if_rdata  = '0;
    d_rvalid  = 1'b0;
    d_rdata   = '0;
    case (r_owner)
      OWN_IF: begin
        if_rvalid = 1'b1;
        if_rdata  = mem_do;
      end
      OWN_DRD: begin
        d_rvalid = 1'b1;
        d_rdata  = mem_do;
      end
      OWN_DWR: begin
        d_rvalid = 1'b1;
      end
      default: ;
    endcase
  end

endmodule
